// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Brief  : Shared size encodings, FSM state encoding and word width for the
//          data-memory load/store path.
// Rev    : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Selects the addressed byte/half lane of a read word and sign- or
//          zero-extends it to a full word.
// Rev    : 1.0  initial release
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              signext,
  output logic [WORD_W-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_B:    data = signext ? {{(WORD_W-8){w_byte[7]}}, w_byte}
                              : {{(WORD_W-8){1'b0}}, w_byte};
      SZ_H:    data = signext ? {{(WORD_W-16){w_half[15]}}, w_half}
                              : {{(WORD_W-16){1'b0}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_access_ctrl
// Brief  : Load/store unit between the core memory port and the data BRAM:
//          lane write enables, read-latency wait and aligned load return.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signext,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [1:0] c_lat_last = 2'(RD_LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rdata;
  logic [1:0]          r_lane;
  logic [1:0]          r_size;
  logic                r_signext;
  logic                r_err;

  logic                w_accept;
  logic                w_err;
  logic [3:0]          w_we;
  logic [WORD_W-1:0]   w_wdata;
  logic [WORD_W-1:0]   w_ld_data;
  logic                w_unused;

  assign w_unused = ^req_addr[WORD_W-1:ADDR_W+2];
  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Alignment check and little-endian lane enables for the incoming request
  always_comb begin
    w_err   = 1'b0;
    w_we    = 4'b0000;
    w_wdata = req_wdata;
    case (req_size)
      SZ_B: begin
        w_we    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        w_err   = req_addr[0];
        w_we    = 4'b0011 << req_addr[1:0];
        w_wdata = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        w_err   = |req_addr[1:0];
        w_we    = 4'b1111;
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mem_en      = !w_err;
          mem_we      = (req_we && !w_err) ? w_we : 4'b0000;
          w_state_nxt = (!req_we && !w_err) ? ST_LD_WAIT : ST_RESP;
        end
      end
      ST_LD_WAIT: if (r_cnt == 2'd0) w_state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured on accept so the BRAM port stays stable while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_lane    <= 2'd0;
      r_size    <= SZ_B;
      r_signext <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= c_lat_last;
      r_addr    <= req_addr[ADDR_W+1:2];
      r_wdata   <= w_wdata;
      r_rdata   <= '0;
      r_lane    <= req_addr[1:0];
      r_size    <= req_size;
      r_signext <= req_signext;
      r_err     <= w_err;
    end else if (r_state == ST_LD_WAIT) begin
      if (r_cnt == 2'd0) r_rdata <= w_ld_data;
      else               r_cnt   <= r_cnt - 2'd1;
    end
  end

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr    (r_lane),
    .size    (r_size),
    .signext (r_signext),
    .data    (w_ld_data)
  );

  assign mem_addr   = w_accept ? req_addr[ADDR_W+1:2] : r_addr;
  assign mem_wdata  = w_accept ? w_wdata : r_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_access_ctrl
// Brief  : Scoreboard bench driving two instances (read latency 1 and 3) with
//          the same directed requests against behavioural BRAM models.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_signext = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        ready_a [2];
  logic        rv_a    [2];
  logic        err_a   [2];
  logic        en_a    [2];
  logic [3:0]  we_a    [2];
  logic [9:0]  addr_a  [2];
  logic [31:0] rd_a    [2];
  logic [31:0] wd_a    [2];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int acc_cyc [2] = '{-10, -10};
  int busy_until [2] = '{0, 0};

  typedef struct packed {
    int          t;
    logic        en;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } mp_t;

  typedef struct packed {
    int          inst;
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  mp_t  mq [$];
  rsp_t rq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem_rdata;
    logic [31:0] mem  [0:1023];
    logic [31:0] pipe [0:LAT-1];

    dmem_access_ctrl #(.ADDR_W(10), .RD_LATENCY(LAT)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_signext (req_signext),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (ready_a[g]),
      .resp_valid  (rv_a[g]),
      .resp_rdata  (rd_a[g]),
      .resp_err    (err_a[g]),
      .mem_en      (en_a[g]),
      .mem_we      (we_a[g]),
      .mem_addr    (addr_a[g]),
      .mem_wdata   (wd_a[g]),
      .mem_rdata   (mem_rdata)
    );

    assign mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
      if (en_a[g]) begin
        for (int b = 0; b < 4; b++)
          if (we_a[g][b]) mem[addr_a[g]][8*b +: 8] <= wd_a[g][8*b +: 8];
        pipe[0] <= mem[addr_a[g]];
      end
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  always @(negedge clk) begin
    mp_t e;
    int  idx;
    int  j;
    logic exp_rdy;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ready_a[k] !== 1'b1 || rv_a[k] !== 1'b0 || err_a[k] !== 1'b0 || rd_a[k] !== 32'd0 ||
            en_a[k] !== 1'b0 || we_a[k] !== 4'd0 || addr_a[k] !== 10'd0 || wd_a[k] !== 32'd0) begin
          bad++;
          $display("FAIL reset_vals inst%0d cyc%0d: got ready=%b rv=%b err=%b rdata=%h en=%b we=%b addr=%h wdata=%h, want 1 0 0 0 0 0 0 0",
                   k, cyc, ready_a[k], rv_a[k], err_a[k], rd_a[k], en_a[k], we_a[k], addr_a[k], wd_a[k]);
        end
      end
    end else begin
      if (mq.size() > 0 && mq[0].t == cyc) begin
        e = mq.pop_front();
        for (int k = 0; k < 2; k++) begin
          total++;
          if (en_a[k] !== e.en || we_a[k] !== e.we || (e.en && addr_a[k] !== e.addr) ||
              (e.we != 4'd0 && wd_a[k] !== e.wdata)) begin
            bad++;
            $display("FAIL mem_port inst%0d cyc%0d: got en=%b we=%b addr=%h wdata=%h, want en=%b we=%b addr=%h wdata=%h",
                     k, cyc, en_a[k], we_a[k], addr_a[k], wd_a[k], e.en, e.we, e.addr, e.wdata);
          end
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          total++;
          if (en_a[k] !== 1'b0 || we_a[k] !== 4'd0) begin
            bad++;
            $display("FAIL mem_idle inst%0d cyc%0d: got en=%b we=%b, want en=0 we=0", k, cyc, en_a[k], we_a[k]);
          end
        end
      end

      for (int k = 0; k < 2; k++) begin
        exp_rdy = !(cyc > acc_cyc[k] && cyc < busy_until[k]);
        total++;
        if (ready_a[k] !== exp_rdy) begin
          bad++;
          $display("FAIL req_ready inst%0d cyc%0d: got %b want %b", k, cyc, ready_a[k], exp_rdy);
        end

        j = 0;
        while (j < rq.size()) begin
          if (rq[j].inst == k && rq[j].due < cyc) begin
            total++;
            bad++;
            $display("FAIL resp_missing inst%0d cyc%0d: got no resp_valid, want one at cyc%0d", k, cyc, rq[j].due);
            rq.delete(j);
          end else begin
            j++;
          end
        end

        if (rv_a[k] === 1'b1) begin
          idx = -1;
          for (int i = 0; i < rq.size(); i++)
            if (rq[i].inst == k) begin
              idx = i;
              break;
            end
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL resp_unexpected inst%0d cyc%0d: got resp_valid=1 rdata=%h err=%b, want none", k, cyc, rd_a[k], err_a[k]);
          end else begin
            if (rq[idx].due != cyc || rd_a[k] !== rq[idx].rdata || err_a[k] !== rq[idx].err) begin
              bad++;
              $display("FAIL resp inst%0d: got cyc%0d rdata=%h err=%b, want cyc%0d rdata=%h err=%b",
                       k, cyc, rd_a[k], err_a[k], rq[idx].due, rq[idx].rdata, rq[idx].err);
            end
            rq.delete(idx);
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_we, input logic [31:0] exp_wd);
    int n;
    int d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ready_a[0] && ready_a[1]) && n < 50);
    if (!(ready_a[0] && ready_a[1])) begin
      $display("FAIL ready_timeout: got ready=%b%b want 11", ready_a[1], ready_a[0]);
      $fatal(1, "request port stuck");
    end
    req_valid   = 1'b1;
    req_we      = we;
    req_size    = size;
    req_signext = sx;
    req_addr    = addr;
    req_wdata   = wdata;
    mq.push_back('{t: cyc, en: !exp_err, we: exp_we, addr: addr[11:2], wdata: exp_wd});
    for (int k = 0; k < 2; k++) begin
      d = (!we && !exp_err) ? lat_of(k) + 1 : 1;
      rq.push_back('{inst: k, due: cyc + d, rdata: exp_rd, err: exp_err});
      acc_cyc[k]    = cyc;
      busy_until[k] = cyc + d + 1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'h5555_5555;
    req_wdata = 32'hA5A5_A5A5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b1, SZ_W, 1'b0, 32'h0000_0004, 32'h1280_3456, 32'h0, 1'b0, 4'b1111, 32'h1280_3456);
    issue(1'b1, SZ_W, 1'b0, 32'h0000_0000, 32'h8001_0000, 32'h0, 1'b0, 4'b1111, 32'h8001_0000);
    issue(1'b0, SZ_B, 1'b1, 32'h0000_0006, 32'h0, 32'hFFFF_FF80, 1'b0, 4'b0, 32'h0);
    issue(1'b0, SZ_H, 1'b0, 32'h0000_0002, 32'h0, 32'h0000_8001, 1'b0, 4'b0, 32'h0);
    issue(1'b0, SZ_H, 1'b1, 32'h0000_0002, 32'h0, 32'hFFFF_8001, 1'b0, 4'b0, 32'h0);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0004, 32'h0, 32'h1280_3456, 1'b0, 4'b0, 32'h0);
    issue(1'b1, SZ_B, 1'b0, 32'h0000_0006, 32'h0000_00AB, 32'h0, 1'b0, 4'b0100, 32'hABAB_ABAB);
    issue(1'b0, SZ_B, 1'b0, 32'h0000_0006, 32'h0, 32'h0000_00AB, 1'b0, 4'b0, 32'h0);
    issue(1'b0, SZ_B, 1'b1, 32'h0000_0007, 32'h0, 32'h0000_0012, 1'b0, 4'b0, 32'h0);
    issue(1'b1, SZ_H, 1'b0, 32'h0000_0002, 32'h1234_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0000, 32'h0, 32'hBEEF_0000, 1'b0, 4'b0, 32'h0);
    issue(1'b0, SZ_B, 1'b1, 32'h0000_0003, 32'h0, 32'hFFFF_FFBE, 1'b0, 4'b0, 32'h0);

    // misaligned and reserved-size requests must not touch memory
    issue(1'b1, SZ_W,   1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b0, 32'h0);
    issue(1'b1, SZ_RSV, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b0, 32'h0);
    issue(1'b0, SZ_H,   1'b1, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    issue(1'b0, SZ_W,   1'b0, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    issue(1'b0, SZ_W,   1'b0, 32'h0000_0000, 32'h0, 32'hBEEF_0000, 1'b0, 4'b0, 32'h0);

    // back-to-back store then load of the same word (upper address bits dropped)
    issue(1'b1, SZ_W, 1'b0, 32'h0000_1008, 32'hCAFE_F00D, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b0, 32'h0);

    // reset while both instances sit in LD_WAIT: the response is dropped
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b0, 32'h0);
    rst = 1'b1;
    rq.delete();
    for (int k = 0; k < 2; k++) begin
      acc_cyc[k]    = -10;
      busy_until[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b0, SZ_W, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b0, 32'h0);
    issue(1'b1, SZ_B, 1'b0, 32'h0000_000B, 32'h0000_0011, 32'h0, 1'b0, 4'b1000, 32'h1111_1111);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0008, 32'h0, 32'h11FE_F00D, 1'b0, 4'b0, 32'h0);

    repeat (8) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
